// File: rtl/phase_select_ctrl.sv
// phase_select_ctrl: bang-bang CDR phase picker driving an 8-way phase mux.
// Ports: clk, rst_n (sync, low), vld/early/late/hold in; select[2:0], step_up, step_dn, locked out.
module phase_select_ctrl #(
  parameter int THRESH   = 8,
  parameter int BLANK    = 2,
  parameter int LOCK_CNT = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vld,
  input  logic       early,
  input  logic       late,
  input  logic       hold,
  output logic [2:0] select,
  output logic       step_up,
  output logic       step_dn,
  output logic       locked
);

  generate
    if (THRESH < 2 || THRESH > 15) begin : g_bad_thresh
      $error("THRESH out of range 2..15");
    end
    if (BLANK < 0 || BLANK > 7) begin : g_bad_blank
      $error("BLANK out of range 0..7");
    end
    if (LOCK_CNT < 1 || LOCK_CNT > 255) begin : g_bad_lock
      $error("LOCK_CNT out of range 1..255");
    end
  endgenerate

  localparam logic signed [5:0] THR_P = 6'(THRESH);
  localparam logic signed [5:0] THR_N = -THR_P;
  localparam logic [2:0] BLANK_LD = 3'(BLANK);
  localparam logic [7:0] LOCK_MAX = 8'(LOCK_CNT);

  logic signed [4:0] acc_q, acc_d;
  logic [2:0] sel_q, sel_d;
  logic [2:0] blank_q, blank_d;
  logic [7:0] lock_q, lock_d;
  logic       up_q, up_d;
  logic       dn_q, dn_d;
  logic       locked_q, locked_d;

  logic              qual;
  logic signed [5:0] vote;
  logic signed [5:0] nxt;
  logic              hit_up;
  logic              hit_dn;

  assign qual = vld & ~hold & (blank_q == 3'd0);

  // Conflicting or absent early/late carries no information.
  always_comb begin
    vote = 6'sd0;
    unique case (1'b1)
      (late & ~early): vote = 6'sd1;
      (early & ~late): vote = -6'sd1;
      default:         vote = 6'sd0;
    endcase
  end

  // Sign-extend so the sum at +/-THRESH never wraps before compare.
  assign nxt    = {acc_q[4], acc_q} + vote;
  assign hit_up = qual & (nxt == THR_P);
  assign hit_dn = qual & (nxt == THR_N);

  always_comb begin
    acc_d    = acc_q;
    sel_d    = sel_q;
    lock_d   = lock_q;
    locked_d = locked_q;
    up_d     = 1'b0;
    dn_d     = 1'b0;
    blank_d  = (blank_q != 3'd0)
             ? blank_q - 3'd1
             : 3'd0;
    if (qual) begin
      unique case (1'b1)
        hit_up: begin
          sel_d    = sel_q + 3'd1;
          acc_d    = 5'sd0;
          up_d     = 1'b1;
          blank_d  = BLANK_LD;
          lock_d   = 8'd0;
          locked_d = 1'b0;
        end
        hit_dn: begin
          sel_d    = sel_q - 3'd1;
          acc_d    = 5'sd0;
          dn_d     = 1'b1;
          blank_d  = BLANK_LD;
          lock_d   = 8'd0;
          locked_d = 1'b0;
        end
        default: begin
          acc_d  = nxt[4:0];
          lock_d = (lock_q < LOCK_MAX)
                 ? lock_q + 8'd1
                 : lock_q;
          locked_d = locked_q
                   | (lock_d == LOCK_MAX);
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q    <= 5'sd0;
      sel_q    <= 3'd0;
      blank_q  <= 3'd0;
      lock_q   <= 8'd0;
      up_q     <= 1'b0;
      dn_q     <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      sel_q    <= sel_d;
      blank_q  <= blank_d;
      lock_q   <= lock_d;
      up_q     <= up_d;
      dn_q     <= dn_d;
      locked_q <= locked_d;
    end
  end

  assign select  = sel_q;
  assign step_up = up_q;
  assign step_dn = dn_q;
  assign locked  = locked_q;

endmodule

// File: tb/tb_phase_select_ctrl.sv
// tb_phase_select_ctrl: directed + random bench for phase_select_ctrl.
// Compares every cycle against an integer reference model.
module tb_phase_select_ctrl;

  localparam int THRESH   = 8;
  localparam int BLANK    = 2;
  localparam int LOCK_CNT = 64;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       vld, early, late, hold;
  logic [2:0] select;
  logic       step_up, step_dn, locked;

  int n_cmp = 0;
  int n_err = 0;

  int m_sel, m_acc, m_blank, m_lcnt;
  int m_locked, m_up, m_dn;

  phase_select_ctrl #(
    .THRESH(THRESH),
    .BLANK(BLANK),
    .LOCK_CNT(LOCK_CNT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .vld(vld),
    .early(early),
    .late(late),
    .hold(hold),
    .select(select),
    .step_up(step_up),
    .step_dn(step_dn),
    .locked(locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic model(input bit r, input bit v, input bit e,
                       input bit l, input bit h);
    int nb, vote, n;
    if (!r) begin
      m_sel = 0; m_acc = 0; m_blank = 0; m_lcnt = 0;
      m_locked = 0; m_up = 0; m_dn = 0;
      return;
    end
    m_up = 0;
    m_dn = 0;
    nb = (m_blank > 0) ? m_blank - 1 : 0;
    if (v && !h && m_blank == 0) begin
      vote = (l && !e) ? 1 : ((e && !l) ? -1 : 0);
      n = m_acc + vote;
      if (n == THRESH || n == -THRESH) begin
        m_sel = (n > 0) ? (m_sel + 1) % 8 : (m_sel + 7) % 8;
        m_up = (n > 0);
        m_dn = (n < 0);
        m_acc = 0;
        nb = BLANK;
        m_lcnt = 0;
        m_locked = 0;
      end else begin
        m_acc = n;
        if (m_lcnt < LOCK_CNT) m_lcnt++;
        if (m_lcnt == LOCK_CNT) m_locked = 1;
      end
    end
    m_blank = nb;
  endtask

  task automatic cyc(input bit r, input bit v, input bit e,
                     input bit l, input bit h);
    rst_n = r; vld = v; early = e; late = l; hold = h;
    @(posedge clk);
    model(r, v, e, l, h);
    #1;
    chk("sel", int'(select), m_sel);
    chk("up", int'(step_up), m_up);
    chk("dn", int'(step_dn), m_dn);
    chk("locked", int'(locked), m_locked);
  endtask

  task automatic votes(input int n, input bit e, input bit l);
    for (int i = 0; i < n; i++) cyc(1, 1, e, l, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 0; vld = 0; early = 0; late = 0; hold = 0;
    m_sel = 0; m_acc = 0; m_blank = 0; m_lcnt = 0;
    m_locked = 0; m_up = 0; m_dn = 0;

    // reset state
    cyc(0, 1, 0, 1, 1);
    cyc(0, 0, 0, 0, 0);
    chk("rst_sel", int'(select), 0);
    chk("rst_lock", int'(locked), 0);

    // 8 late votes step up; 2 blanked votes ignored
    votes(7, 0, 1);
    chk("pre_sel", int'(select), 0);
    votes(1, 0, 1);
    chk("s1_sel", int'(select), 1);
    chk("s1_up", int'(step_up), 1);
    votes(2, 0, 1);
    votes(7, 0, 1);
    chk("blank_sel", int'(select), 1);
    votes(1, 0, 1);
    chk("s2_sel", int'(select), 2);

    // step down wrap 0->7, then up wrap 7->0
    cyc(0, 0, 0, 0, 0);
    votes(8, 1, 0);
    chk("wrap_dn", int'(select), 7);
    chk("wrap_dn_p", int'(step_dn), 1);
    idle(2);
    votes(8, 0, 1);
    chk("wrap_up", int'(select), 0);
    idle(2);

    // dithering input: no step, lock after 64 qualified cycles
    for (int i = 0; i < 100; i++) begin
      case (i % 4)
        0: votes(1, 0, 1);
        1: votes(1, 1, 0);
        2: votes(1, 1, 1);
        default: votes(1, 0, 0);
      endcase
    end
    chk("dith_sel", int'(select), 0);
    chk("dith_lock", int'(locked), 1);

    // step drops lock on same edge
    votes(8, 0, 1);
    chk("unlk_up", int'(step_up), 1);
    chk("unlk_lock", int'(locked), 0);
    idle(2);

    // hold freezes acc at +7
    votes(7, 0, 1);
    for (int i = 0; i < 10; i++) cyc(1, 1, 0, 1, 1);
    chk("hold_sel", int'(select), 1);
    votes(1, 0, 1);
    chk("hold_up", int'(step_up), 1);
    chk("hold_sel2", int'(select), 2);
    idle(2);

    // reset in blanking after reaching select=3
    votes(8, 0, 1);
    chk("pre_rst_sel", int'(select), 3);
    cyc(0, 1, 0, 1, 1);
    chk("mid_rst_sel", int'(select), 0);
    chk("mid_rst_up", int'(step_up), 0);
    votes(8, 0, 1);
    chk("post_rst", int'(select), 1);

    // random traffic with drifting bias
    for (int i = 0; i < 4000; i++) begin
      int pl, pe;
      bit r, v, h, e, l;
      case ((i / 150) % 3)
        0: begin pl = 60; pe = 20; end
        1: begin pl = 20; pe = 60; end
        default: begin pl = 40; pe = 40; end
      endcase
      r = ($urandom_range(0, 599) != 0);
      v = ($urandom_range(0, 3) != 0);
      h = ($urandom_range(0, 15) == 0);
      l = ($urandom_range(0, 99) < pl);
      e = ($urandom_range(0, 99) < pe);
      cyc(r, v, e, l, h);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/phase_select_ctrl.md
PHASE_SELECT_CTRL -- requirements
Module: phase_select_ctrl

Interface
REQ-001 The block SHALL have the parameter THRESH, default 8: vote count magnitude that triggers one phase step; legal range 2..15.
REQ-002 The block SHALL have the parameter BLANK, default 2: cycles during which votes are ignored after a phase step, covering mux8 settling; legal range 0..7.
REQ-003 The block SHALL have the parameter LOCK_CNT, default 64: consecutive qualified votes without a step needed to assert locked; legal range 1..255.
REQ-004 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have the port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-006 The block SHALL have the port vld, input, 1 bit: the phase-detector early/late pair is valid this cycle.
REQ-007 The block SHALL have the port early, input, 1 bit: data edge is ahead of the sampling phase.
REQ-008 The block SHALL have the port late, input, 1 bit: data edge is behind the sampling phase.
REQ-009 The block SHALL have the port hold, input, 1 bit: freeze the loop (acc, select, lock_cnt).
REQ-010 The block SHALL have the port select, output, 3 bits: the registered phase index driving the mux8 select.
REQ-011 The block SHALL have the port step_up, output, 1 bit: one-cycle pulse, select incremented this cycle.
REQ-012 The block SHALL have the port step_dn, output, 1 bit: one-cycle pulse, select decremented this cycle.
REQ-013 The block SHALL have the port locked, output, 1 bit: loop is stable.

Function
REQ-014 The block SHALL treat a cycle as qualified only when vld=1, hold=0 and the blanking counter is 0.
REQ-015 The block SHALL, on each qualified cycle, produce vote = +1 if late=1 and early=0, -1 if early=1 and late=0, else 0 (both or neither asserted).
REQ-016 The block SHALL hold the signed accumulator acc in 5 bits; next = acc + vote, with no other modification except as specified below.
REQ-017 The block SHALL, when next = +THRESH, set select to (select+1) mod 8 (7 wraps to 0), clear acc to 0, assert step_up for exactly one cycle and load the blanking counter with BLANK, all on the same edge.
REQ-018 The block SHALL, when next = -THRESH, set select to (select-1) mod 8 (0 wraps to 7), clear acc to 0, assert step_dn for exactly one cycle and load the blanking counter with BLANK.
REQ-019 The block SHALL have a latency of one cycle: a vote sampled at edge N that reaches threshold changes select and pulses step_* visible after edge N; acc never holds ±THRESH.
REQ-020 The block SHALL never assert step_up and step_dn in the same cycle; when no step occurs, both SHALL be 0.
REQ-021 The blanking counter SHALL decrement by 1 each cycle while nonzero, regardless of vld and hold; with BLANK=0 there is no blanking.
REQ-022 The block SHALL keep acc, select and lock_cnt unchanged while hold=1; blanking continues to count down; step_* SHALL be 0.
REQ-023 The 8-bit lock_cnt SHALL increment on each qualified cycle that does not cause a step, saturating at LOCK_CNT.
REQ-024 Any step SHALL clear lock_cnt to 0 and deassert locked on the same edge.
REQ-025 The block SHALL assert locked (registered) when lock_cnt = LOCK_CNT, and hold it until a step or reset.
REQ-026 The block SHALL drive select only from a register; select is stable for the whole cycle (no glitches into mux8).

Reset
REQ-027 The block SHALL, when rst_n=0 at a rising clk edge, set select=0, acc=0, blanking=0, lock_cnt=0, step_up=0, step_dn=0 and locked=0.
REQ-028 Reset SHALL take priority over every other input, including mid-blanking, mid-step and hold=1; normal operation SHALL resume on the first edge with rst_n=1.

Verification
REQ-029 The bench SHALL cover: reset, then 8 cycles vld=1, late=1 -> step_up after the 8th edge, select 0->1, acc=0; the next 2 votes are ignored, so acc stays 0.
REQ-030 The bench SHALL cover: select=0, acc=0; 8 qualified early votes -> step_dn, select=7 (wrap); repeat from select=7 with late votes -> select returns to 0 via 7->0 wrap.
REQ-031 The bench SHALL cover: alternating late/early, plus both-set and neither-set cycles, for 100 vld cycles -> no step, acc within ±1, locked=1 after the 64th qualified vote.
REQ-032 The bench SHALL cover: locked=1, then 8 late votes -> step_up and locked=0 on the same edge, lock_cnt=0.
REQ-033 The bench SHALL cover: acc=+7, hold=1 with late=1 for 10 cycles -> no change; hold=0 with one late vote -> step_up.
REQ-034 The bench SHALL cover: rst_n=0 asserted during the blanking cycle after a step, with select=3 -> all outputs are reset values after the edge, and select=0.
